// File: rtl/rx_window_controller.sv
// Receive-window sequencer: gates the RX chain, paces sample strobes, runs the
// sample timebase and captures the first peak trigger or a listen timeout.
//
// state  | meaning
// IDLE   | waiting for a start with a non-zero window length
// FLUSH  | chain enabled, discarding samples while filters settle
// LISTEN | timebase running, waiting for a peak trigger or timeout
// DONE   | one-cycle end-of-window report
module rx_window_controller #(
    parameter int SAMPLE_PERIOD = 128,
    parameter int FLUSH_SAMPLES = 64,
    parameter int TIME_W        = 16
) (
    input  logic                crx_clk,
    input  logic                rrx_rst,
    input  logic                erx_en,
    input  logic                i_start,
    input  logic [TIME_W-1:0]   i_window_len,
    input  logic                i_abort,
    input  logic                i_peak_trigger,
    input  logic [3:0]          i_peak_seq,
    input  logic signed [15:0]  i_peak_value,
    output logic                o_rx_en,
    output logic                o_sample_strobe,
    output logic [TIME_W-1:0]   o_current_time,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_detected,
    output logic                o_timeout,
    output logic [3:0]          o_det_seq,
    output logic signed [15:0]  o_det_value,
    output logic [TIME_W-1:0]   o_det_time
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_LISTEN = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int PRESC_W = $clog2(SAMPLE_PERIOD);
    localparam int FLUSH_W = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_PERIOD - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_SAMPLES - 1);

    logic [1:0]          state_q,     state_d;
    logic [PRESC_W-1:0]  presc_q,     presc_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [TIME_W-1:0]   time_q,      time_d;
    logic [TIME_W-1:0]   len_q,       len_d;
    logic                rx_en_q,     rx_en_d;
    logic                detected_q,  detected_d;
    logic                timeout_q,   timeout_d;
    logic [3:0]          det_seq_q,   det_seq_d;
    logic signed [15:0]  det_value_q, det_value_d;
    logic [TIME_W-1:0]   det_time_q,  det_time_d;

    logic busy;
    logic strobe;

    assign busy   = (state_q == ST_FLUSH) || (state_q == ST_LISTEN);
    assign strobe = busy && erx_en && (presc_q == PRESC_LAST);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        flush_cnt_d = flush_cnt_q;
        time_d      = time_q;
        len_d       = len_q;
        rx_en_d     = rx_en_q;
        detected_d  = detected_q;
        timeout_d   = timeout_q;
        det_seq_d   = det_seq_q;
        det_value_d = det_value_q;
        det_time_d  = det_time_q;

        // With the global enable low everything holds; only the output gate drops rx_en.
        if (erx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && (i_window_len != '0)) begin
                        len_d       = i_window_len;
                        detected_d  = 1'b0;
                        timeout_d   = 1'b0;
                        det_seq_d   = '0;
                        det_value_d = '0;
                        det_time_d  = '0;
                        presc_d     = '0;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end
                end
                ST_FLUSH, ST_LISTEN: begin
                    presc_d = strobe ? '0 : presc_q + PRESC_W'(1);
                    if (i_abort) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_FLUSH) begin
                        if (strobe) begin
                            if (flush_cnt_q == '0) begin
                                state_d = ST_LISTEN;
                                time_d  = '0;
                            end else begin
                                flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                            end
                        end
                    end else begin
                        if (strobe) begin
                            time_d = time_q + TIME_W'(1);
                        end
                        // A trigger on the final strobe still counts as a detection.
                        if (i_peak_trigger) begin
                            det_seq_d   = i_peak_seq;
                            det_value_d = i_peak_value;
                            det_time_d  = time_q;
                            detected_d  = 1'b1;
                            state_d     = ST_DONE;
                        end else if (strobe && (time_q == len_q - TIME_W'(1))) begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            rx_en_d = (state_d == ST_FLUSH) || (state_d == ST_LISTEN);
        end
    end

    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            flush_cnt_q <= '0;
            time_q      <= '0;
            len_q       <= '0;
            rx_en_q     <= 1'b0;
            detected_q  <= 1'b0;
            timeout_q   <= 1'b0;
            det_seq_q   <= '0;
            det_value_q <= '0;
            det_time_q  <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            flush_cnt_q <= flush_cnt_d;
            time_q      <= time_d;
            len_q       <= len_d;
            rx_en_q     <= rx_en_d;
            detected_q  <= detected_d;
            timeout_q   <= timeout_d;
            det_seq_q   <= det_seq_d;
            det_value_q <= det_value_d;
            det_time_q  <= det_time_d;
        end
    end

    assign o_rx_en         = rx_en_q & erx_en;
    assign o_sample_strobe = strobe;
    assign o_current_time  = time_q;
    assign o_busy          = busy;
    assign o_done          = (state_q == ST_DONE);
    assign o_detected      = detected_q;
    assign o_timeout       = timeout_q;
    assign o_det_seq       = det_seq_q;
    assign o_det_value     = det_value_q;
    assign o_det_time      = det_time_q;

endmodule

// File: tb/tb_rx_window_controller.sv
// Bench for rx_window_controller: per-window outcomes and strobe times are
// predicted from enabled-cycle arithmetic and checked by a negedge monitor.
module tb_rx_window_controller;

    localparam int P  = 4;
    localparam int F  = 2;
    localparam int TW = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b1;
    logic                start = 1'b0;
    logic [TW-1:0]       wlen = '0;
    logic                abort = 1'b0;
    logic                trig = 1'b0;
    logic [3:0]          pseq = '0;
    logic signed [15:0]  pval = '0;

    logic                o_rx_en, o_sample_strobe, o_busy, o_done, o_detected, o_timeout;
    logic [TW-1:0]       o_current_time, o_det_time;
    logic [3:0]          o_det_seq;
    logic signed [15:0]  o_det_value;

    rx_window_controller #(.SAMPLE_PERIOD(P), .FLUSH_SAMPLES(F), .TIME_W(TW)) dut (
        .crx_clk(clk), .rrx_rst(rst), .erx_en(en), .i_start(start), .i_window_len(wlen),
        .i_abort(abort), .i_peak_trigger(trig), .i_peak_seq(pseq), .i_peak_value(pval),
        .o_rx_en(o_rx_en), .o_sample_strobe(o_sample_strobe), .o_current_time(o_current_time),
        .o_busy(o_busy), .o_done(o_done), .o_detected(o_detected), .o_timeout(o_timeout),
        .o_det_seq(o_det_seq), .o_det_value(o_det_value), .o_det_time(o_det_time)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        bit                 det;
        bit                 tmo;
        logic [3:0]         sq;
        logic signed [15:0] val;
        logic [TW-1:0]      t;
    } res_t;

    res_t exp_q[$];
    int   stb_q[$];
    res_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done_prev = 1'b0;
    bit   last_det = 1'b0;
    bit   last_tmo = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: end-of-window reports and strobe times.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_cycle", cyc, mon_e.cyc);
                    check("detected", o_detected, mon_e.det);
                    check("timeout", o_timeout, mon_e.tmo);
                    check("det_seq", o_det_seq, mon_e.sq);
                    check("det_value", o_det_value, mon_e.val);
                    check("det_time", o_det_time, mon_e.t);
                end
            end
            if (o_sample_strobe) begin
                if (stb_q.size() == 0) check("unexpected_strobe", cyc, -1);
                else check("strobe_cycle", cyc, stb_q.pop_front());
            end
        end
        done_prev = o_done && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_en"}, o_rx_en, 0);
        check({tag, "_strobe"}, o_sample_strobe, 0);
        check({tag, "_time"}, o_current_time, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_detected"}, o_detected, 0);
        check({tag, "_timeout"}, o_timeout, 0);
        check({tag, "_det_seq"}, o_det_seq, 0);
        check({tag, "_det_value"}, o_det_value, 0);
        check({tag, "_det_time"}, o_det_time, 0);
    endtask

    // eff = number of enabled cycles since the start edge; all timing follows from it.
    task automatic run_window(input int len, input int trig_eff, input int abort_eff,
                              input int rst_eff, input int frz_eff, input int frz_len,
                              input bit rnd_en, input bit rnd_start,
                              input logic [3:0] sq, input logic signed [15:0] v);
        int   eff, guard, frz_left;
        bit   fin, aborted, reset_hit, en_now;
        res_t r;
        r.cyc = 0; r.det = 0; r.tmo = 0; r.sq = '0; r.val = '0; r.t = '0;
        start = 1'b1; wlen = TW'(len); en = 1'b1; pseq = sq; pval = v;
        tick();
        start = 1'b0;
        eff = 1; guard = 0; frz_left = frz_len;
        fin = 0; aborted = 0; reset_hit = 0;
        while (!fin) begin
            guard++;
            if (guard > 4000) begin
                check("window_bound", 0, 1);
                break;
            end
            en_now = 1'b1;
            if (eff == frz_eff && frz_left > 0) begin
                en_now = 1'b0;
                frz_left--;
            end else if (rnd_en && $urandom_range(0, 5) == 0) begin
                en_now = 1'b0;
            end
            en    = en_now;
            trig  = en_now && (eff == trig_eff);
            abort = en_now && (eff == abort_eff);
            rst   = en_now && (eff == rst_eff);
            if (rnd_start) begin
                start = ($urandom_range(0, 9) == 0);
                wlen  = TW'($urandom_range(0, 20));
            end
            if (en_now && !rst && (eff % P == 0)) stb_q.push_back(cyc);
            @(negedge clk);
            if (!rst) begin
                check("busy", o_busy, 1);
                check("rx_en", o_rx_en, en_now);
                if (eff == 1) begin
                    check("start_clr_detected", o_detected, 0);
                    check("start_clr_timeout", o_timeout, 0);
                    check("start_clr_det_time", o_det_time, 0);
                end
                if (eff > P * F) check("current_time", o_current_time, (eff - 1) / P - F);
            end
            if (en_now) begin
                if (rst) begin
                    reset_hit = 1; fin = 1;
                end else if (abort) begin
                    aborted = 1; fin = 1;
                end else if (trig && eff > P * F) begin
                    r.cyc = cyc + 1; r.det = 1; r.tmo = 0; r.sq = sq; r.val = v;
                    r.t = TW'((eff - 1) / P - F);
                    exp_q.push_back(r); fin = 1;
                end else if (eff == P * (F + len)) begin
                    r.cyc = cyc + 1; r.det = 0; r.tmo = 1;
                    exp_q.push_back(r); fin = 1;
                end else begin
                    eff++;
                end
            end
            tick();
            trig = 1'b0; abort = 1'b0; start = 1'b0;
        end
        rst = 1'b0; en = 1'b1;
        if (reset_hit) begin
            @(negedge clk);
            check_all_zero("midreset");
            last_det = 0; last_tmo = 0;
            tick();
        end else if (aborted) begin
            @(negedge clk);
            check("abort_rx_en", o_rx_en, 0);
            check("abort_busy", o_busy, 0);
            check("abort_done", o_done, 0);
            check("abort_detected", o_detected, 0);
            check("abort_timeout", o_timeout, 0);
            last_det = 0; last_tmo = 0;
            tick();
        end else begin
            start = 1'b1; wlen = TW'(5);
            @(negedge clk);
            check("end_rx_en", o_rx_en, 0);
            check("end_busy", o_busy, 0);
            tick();
            start = 1'b0;
            @(negedge clk);
            check("done_single", o_done, 0);
            check("start_in_done_ignored", o_busy, 0);
            check("flag_hold_det", o_detected, r.det);
            check("flag_hold_tmo", o_timeout, r.tmo);
            last_det = r.det; last_tmo = r.tmo;
            tick();
        end
    endtask

    initial begin
        int len, mx, te, ae;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        run_window(10, -1, -1, -1, -1, 0, 0, 0, 4'd0, 16'sd0);
        run_window(100, 38, -1, -1, -1, 0, 0, 0, 4'd5, -16'sd1234);
        run_window(3, 5, -1, -1, -1, 0, 0, 0, 4'd9, 16'sd77);
        run_window(3, 20, -1, -1, -1, 0, 0, 0, 4'd3, 16'sd500);
        run_window(8, -1, 26, -1, -1, 0, 0, 0, 4'd0, 16'sd0);
        run_window(12, -1, -1, -1, 26, 20, 0, 0, 4'd0, 16'sd0);

        start = 1'b1; wlen = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("len0_busy", o_busy, 0);
            check("len0_rx_en", o_rx_en, 0);
            check("len0_hold_det", o_detected, last_det);
            check("len0_hold_tmo", o_timeout, last_tmo);
            tick();
        end

        run_window(6, -1, -1, 15, -1, 0, 0, 0, 4'd0, 16'sd0);

        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(1, 12);
            mx  = P * (F + len);
            te  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, mx + 4);
            ae  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, mx) : -1;
            run_window(len, te, ae, -1, -1, 0, 1, 1, 4'($urandom_range(0, 15)),
                       16'($urandom_range(0, 65535)));
        end

        repeat (4) tick();
        check("pending_results", exp_q.size(), 0);
        check("pending_strobes", stb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_window_controller.md
Name: rx_window_controller

Overview:
Sequences the receive chain for one listen window. It gates the chain's enable, generates the per-sample strobe (one per SAMPLE_PERIOD clocks) and runs a sample-count timebase that feeds the peak finder's current-time input. It holds the chain through a filter flush interval, then captures the first peak trigger (sequence, value, timestamp) or declares a timeout, and reports the result to the ARM side.

Parameters:
SAMPLE_PERIOD, 128, clocks per input sample; must be >= 2.
FLUSH_SAMPLES, 64, sample periods discarded after enable while the filters and correlator settle; must be >= 1.
TIME_W, 16, width of the timebase and of the captured timestamp.

Ports:
crx_clk  in  1  clock.
rrx_rst  in  1  reset, synchronous, active-high.
erx_en  in  1  global enable; when low, all state, counters and outputs hold, except o_rx_en, which is forced 0.
i_start  in  1  one-cycle pulse that starts a window.
i_window_len  in  TIME_W  listen length in samples; latched on an accepted i_start.
i_abort  in  1  cancels the current window.
i_peak_trigger  in  1  peak-finder trigger (one-cycle pulse).
i_peak_seq  in  4  identified sequence, valid with i_peak_trigger.
i_peak_value  in  16 signed  peak value, valid with i_peak_trigger.
o_rx_en  out  1  registered enable to the receive chain.
o_sample_strobe  out  1  one-cycle pulse per sample period while busy.
o_current_time  out  TIME_W  timebase (samples since LISTEN entry).
o_busy  out  1  high in FLUSH and LISTEN.
o_done  out  1  one-cycle pulse when a window ends normally.
o_detected  out  1  last window ended on a detection.
o_timeout  out  1  last window ended on a timeout.
o_det_seq  out  4  captured sequence.
o_det_value  out  16 signed  captured peak value.
o_det_time  out  TIME_W  captured timestamp.

Behaviour:
- Reset values: state IDLE; every output 0; prescaler 0; timebase 0; latched length 0.
- States: IDLE, FLUSH, LISTEN, DONE.
- IDLE:
  - An i_start with i_window_len != 0 is accepted: latch the length, clear o_detected, o_timeout and the det_* outputs, clear the prescaler and flush counter, go to FLUSH.
  - An i_start with length 0 is ignored.
- Timing after an accepted start (i_start sampled high at edge T):
  - o_busy=1 and o_rx_en=1 from T+1.
  - First o_sample_strobe at T+SAMPLE_PERIOD, then every SAMPLE_PERIOD clocks.
- Prescaler: counts 0..SAMPLE_PERIOD-1 in FLUSH and LISTEN; the strobe fires on the cycle the count equals SAMPLE_PERIOD-1, then the count wraps to 0.
- FLUSH:
  - Counts strobes; i_peak_trigger is ignored.
  - On the FLUSH_SAMPLES-th strobe, go to LISTEN with o_current_time=0.
  - The prescaler keeps running across the transition without restart.
- LISTEN:
  - o_current_time increments by 1 on each strobe (mod 2^TIME_W).
  - i_peak_trigger high: capture i_peak_seq, i_peak_value and the o_current_time present in that cycle; set o_detected; go to DONE.
  - Otherwise, a strobe with o_current_time == latched_len-1: set o_timeout; go to DONE.
  - Trigger and timeout in the same cycle: detection wins; o_timeout stays 0.
- DONE:
  - Lasts exactly one cycle: o_done=1, o_rx_en=0, o_busy=0, no strobe; next state IDLE.
  - o_detected, o_timeout and det_* hold until the next accepted start.
- i_abort: in FLUSH or LISTEN, go to IDLE on the next edge with o_rx_en=0, o_busy=0, no o_done and flags unchanged (0). It has priority over trigger and timeout in the same cycle. In IDLE or DONE it has no effect.
- i_start while busy or in DONE: ignored.
- o_rx_en low for at least one cycle between windows, so the chain re-initialises its filters.
- erx_en low mid-window: state, prescaler, flush count and timebase freeze; o_rx_en=0; no strobe; inputs ignored. Operation resumes where it stopped when erx_en rises.
- rrx_rst mid-window: immediate return to reset values on that edge.

Test Plan:
Use SAMPLE_PERIOD=4, FLUSH_SAMPLES=2, TIME_W=16.
- Reset, then i_start with len=10 at edge T, no triggers -> o_rx_en=1 from T+1; strobes at T+4, T+8, ...; LISTEN entered after the strobe at T+8; o_timeout=1 and o_done pulse after the 10th LISTEN strobe (T+48); o_rx_en=0 one cycle later.
- i_start len=100, i_peak_trigger with seq=5, value=-1234 when o_current_time=7 -> o_detected=1, o_det_seq=5, o_det_value=-1234, o_det_time=7, single o_done pulse, o_timeout=0.
- Trigger during FLUSH, then none in LISTEN (len=3) -> trigger ignored; ends with o_timeout=1, o_detected=0.
- len=3, trigger in the same cycle as the 3rd LISTEN strobe -> o_detected=1, o_timeout=0, o_det_time=2.
- i_abort in LISTEN at time 4 -> IDLE on the next edge, o_rx_en=0, no o_done, flags 0; a following i_start is accepted.
- erx_en low for 20 cycles mid-LISTEN -> o_current_time and the prescaler hold, o_rx_en=0, no strobes; after re-enable the strobe spacing continues from the frozen phase; i_start with len=0 -> ignored, o_busy stays 0.
